// File: rtl/mem_pkg.sv
// Purpose: shared FSM/owner encodings and default geometry for mem_arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DATA_BASE = 128;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Purpose: counts consecutive fetch losses, saturating at LIMIT.
// Latency: count updates on the clock after inc/clr; at_limit is a decode of the count.
// Backpressure: none; clr takes priority over inc.
module mem_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int            CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAXV = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  // Clear on a fetch grant, otherwise count data wins over a waiting fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != MAXV)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_limit = (r_cnt == MAXV);

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: two-port (fetch/data) arbiter onto one single-cycle shared memory; MEM_PROTECT_EN blocks writes below DATA_BASE.
// Latency: request seen in IDLE cycle N, memory driven in N+1, valid pulse in N+2; one access per 2 cycles.
// Backpressure: x_stall = x_req & ~x_valid; requester holds its request until valid; data wins unless fetch is starved.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DATA_BASE    = DEF_DATA_BASE,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fault
);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_valid;
  logic              r_d_valid;

  logic w_if_elig;
  logic w_d_elig;
  logic w_grant;
  logic w_grant_i;
  logic w_at_limit;
  logic w_acc;
  logic w_acc_i;
  logic w_acc_d;
  logic w_low_addr;
  logic w_blocked;

  // A port that is receiving its valid this cycle does not compete.
  assign w_if_elig  = if_req & ~r_if_valid;
  assign w_d_elig   = d_req & ~r_d_valid;
  assign w_acc      = (r_state == ACC);
  assign w_acc_i    = w_acc & (r_owner == OWN_I);
  assign w_acc_d    = w_acc & (r_owner == OWN_D);
  assign w_low_addr = (r_addr < ADDR_W'(DATA_BASE));

  // Next-state and grant decision: data first unless fetch has lost too often.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_i   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_if_elig || w_d_elig) begin
          w_grant     = 1'b1;
          w_grant_i   = w_if_elig & (~w_d_elig | w_at_limit);
          w_state_nxt = ACC;
        end
      end
      ACC:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (w_grant & ~w_grant_i & if_req),
    .clr      (w_grant_i),
    .at_limit (w_at_limit)
  );

  // State register and winner operand latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= OWN_I;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner <= w_grant_i ? OWN_I : OWN_D;
        r_addr  <= w_grant_i ? if_addr : d_addr;
        r_wdata <= w_grant_i ? '0 : d_wdata;
        r_we    <= ~w_grant_i & d_we;
      end
    end
  end

  // Completion: capture read data at the end of ACC and pulse the owner's valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_valid <= w_acc_i;
      r_d_valid  <= w_acc_d;
      if (w_acc_i) begin
        r_if_rdata <= mem_rdata;
      end
      if (w_acc_d && !r_we) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

`ifdef MEM_PROTECT_EN
  logic r_fault;

  assign w_blocked = w_low_addr;

  // A suppressed write still completes; fault lines up with its d_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_acc_d & r_we & w_blocked;
    end
  end

  assign fault = r_fault;
`else
  // Region decode is still elaborated so DATA_BASE stays in use; nothing is ever blocked.
  assign w_blocked = w_low_addr & 1'b0;
  assign fault     = 1'b0;
`endif

  // Memory is driven only during ACC; a reset landing on ACC aborts the write.
  assign mem_addr  = w_acc ? r_addr : '0;
  assign mem_wdata = w_acc ? r_wdata : '0;
  assign mem_wen   = rst_n & w_acc_d & r_we & ~w_blocked;

  assign if_rdata = r_if_rdata;
  assign if_valid = r_if_valid;
  assign if_stall = if_req & ~r_if_valid;
  assign d_rdata  = r_d_rdata;
  assign d_valid  = r_d_valid;
  assign d_stall  = d_req & ~r_d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: bench for mem_arbiter: directed vector table, starvation sequence, randomized run vs a rule model.
// Latency: checks the N / N+1 / N+2 request-access-valid timing.
// Backpressure: requesters hold until valid; random phase also withdraws requests early.
module tb_mem_arbiter;

`ifdef MEM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  localparam int LIM = 4;

  logic       clk;
  logic       rst_n;
  logic       if_req;
  logic [7:0] if_addr;
  logic [7:0] if_rdata;
  logic       if_valid;
  logic       if_stall;
  logic       d_req;
  logic       d_we;
  logic [7:0] d_addr;
  logic [7:0] d_wdata;
  logic [7:0] d_rdata;
  logic       d_valid;
  logic       d_stall;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wen;
  logic [7:0] mem_rdata;
  logic       fault;

  logic [7:0] mem_a [256];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W       (8),
    .DATA_W       (8),
    .DATA_BASE    (128),
    .STARVE_LIMIT (LIM)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_stall  (if_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .d_stall   (d_stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared memory: combinational read, write on the rising edge.
  assign mem_rdata = mem_a[mem_addr];
  always @(posedge clk) begin
    if (mem_wen) mem_a[mem_addr] = mem_wdata;
  end

  function automatic logic [7:0] pre(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       chk;
    bit       rst;
    bit       ir;
    bit [7:0] ia;
    bit       dr;
    bit       dw;
    bit [7:0] da;
    bit [7:0] dwd;
    bit [7:0] e_ma;
    bit [7:0] e_mwd;
    bit       e_wen;
    bit       e_iv;
    bit [7:0] e_ird;
    bit       e_is;
    bit       e_dv;
    bit [7:0] e_drd;
    bit       e_ds;
    bit       e_flt;
    bit [7:0] e_m200;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  // Rule model state for the random phase.
  bit         m_acc, m_own_d, m_we, m_iv, m_dv, m_flt;
  logic [7:0] m_addr, m_wd, m_ird, m_drd;
  int         m_starve;
  logic [7:0] ref_mem [256];

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) mem_a[i] = pre(i);
    mem_a[5]   = 8'h3C;
    mem_a[200] = 8'h00;
    mem_a[10]  = 8'h55;

    //          chk rst ir ia     dr dw da     dwd    | ma     mwd    wen    iv ird    is dv drd    ds flt   m200
    tbl[0]  = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,     0, 8'h00, 0, 0, 8'h00, 0, 0,    8'h00};
    tbl[1]  = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,     0, 8'h00, 0, 0, 8'h00, 0, 0,    8'h00};
    tbl[2]  = '{1, 1, 1, 8'h05, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,     0, 8'h00, 1, 0, 8'h00, 0, 0,    8'h00};
    tbl[3]  = '{1, 1, 1, 8'h05, 0, 0, 8'h00, 8'h00, 8'h05, 8'h00, 0,     0, 8'h00, 1, 0, 8'h00, 0, 0,    8'h00};
    tbl[4]  = '{1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,     1, 8'h3C, 0, 0, 8'h00, 0, 0,    8'h00};
    tbl[5]  = '{1, 1, 0, 8'h00, 1, 1, 8'hC8, 8'h96, 8'h00, 8'h00, 0,     0, 8'h3C, 0, 0, 8'h00, 1, 0,    8'h00};
    tbl[6]  = '{1, 1, 0, 8'h00, 1, 1, 8'hC8, 8'h96, 8'hC8, 8'h96, 1,     0, 8'h3C, 0, 0, 8'h00, 1, 0,    8'h00};
    tbl[7]  = '{1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,     0, 8'h3C, 0, 1, 8'h00, 0, 0,    8'h96};
    tbl[8]  = '{1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,     0, 8'h3C, 0, 0, 8'h00, 0, 0,    8'h96};
    tbl[9]  = '{1, 1, 0, 8'h00, 1, 0, 8'hC8, 8'h00, 8'h00, 8'h00, 0,     0, 8'h3C, 0, 0, 8'h00, 1, 0,    8'h96};
    tbl[10] = '{1, 1, 0, 8'h00, 1, 0, 8'hC8, 8'h00, 8'hC8, 8'h00, 0,     0, 8'h3C, 0, 0, 8'h00, 1, 0,    8'h96};
    tbl[11] = '{1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,     0, 8'h3C, 0, 1, 8'h96, 0, 0,    8'h96};
    tbl[12] = '{1, 1, 0, 8'h00, 1, 1, 8'hC8, 8'h11, 8'h00, 8'h00, 0,     0, 8'h3C, 0, 0, 8'h96, 1, 0,    8'h96};
    tbl[13] = '{1, 0, 0, 8'h00, 1, 1, 8'hC8, 8'h11, 8'hC8, 8'h11, 0,     0, 8'h3C, 0, 0, 8'h96, 1, 0,    8'h96};
    tbl[14] = '{1, 1, 0, 8'h00, 1, 1, 8'hC8, 8'h11, 8'h00, 8'h00, 0,     0, 8'h00, 0, 0, 8'h00, 1, 0,    8'h96};
    tbl[15] = '{1, 1, 0, 8'h00, 1, 1, 8'hC8, 8'h11, 8'hC8, 8'h11, 1,     0, 8'h00, 0, 0, 8'h00, 1, 0,    8'h96};
    tbl[16] = '{1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,     0, 8'h00, 0, 1, 8'h00, 0, 0,    8'h11};
    tbl[17] = '{1, 1, 0, 8'h00, 1, 1, 8'h0A, 8'hAA, 8'h00, 8'h00, 0,     0, 8'h00, 0, 0, 8'h00, 1, 0,    8'h11};
    tbl[18] = '{1, 1, 0, 8'h00, 1, 1, 8'h0A, 8'hAA, 8'h0A, 8'hAA, !PROT, 0, 8'h00, 0, 0, 8'h00, 1, 0,    8'h11};
    tbl[19] = '{1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,     0, 8'h00, 0, 1, 8'h00, 0, PROT, 8'h11};

    // Directed vectors: lone fetch, lone write/read, reset mid-access, protected write.
    for (int i = 0; i < NV; i++) begin
      tick();
      rst_n = tbl[i].rst; if_req = tbl[i].ir; if_addr = tbl[i].ia;
      d_req = tbl[i].dr; d_we = tbl[i].dw; d_addr = tbl[i].da; d_wdata = tbl[i].dwd;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("v%0d.mem_addr", i),  64'(mem_addr),  64'(tbl[i].e_ma));
        chk($sformatf("v%0d.mem_wdata", i), 64'(mem_wdata), 64'(tbl[i].e_mwd));
        chk($sformatf("v%0d.mem_wen", i),   64'(mem_wen),   64'(tbl[i].e_wen));
        chk($sformatf("v%0d.if_valid", i),  64'(if_valid),  64'(tbl[i].e_iv));
        chk($sformatf("v%0d.if_rdata", i),  64'(if_rdata),  64'(tbl[i].e_ird));
        chk($sformatf("v%0d.if_stall", i),  64'(if_stall),  64'(tbl[i].e_is));
        chk($sformatf("v%0d.d_valid", i),   64'(d_valid),   64'(tbl[i].e_dv));
        chk($sformatf("v%0d.d_rdata", i),   64'(d_rdata),   64'(tbl[i].e_drd));
        chk($sformatf("v%0d.d_stall", i),   64'(d_stall),   64'(tbl[i].e_ds));
        chk($sformatf("v%0d.fault", i),     64'(fault),     64'(tbl[i].e_flt));
        chk($sformatf("v%0d.mem200", i),    64'(mem_a[200]), 64'(tbl[i].e_m200));
      end
    end
    chk("protect.mem10", 64'(mem_a[10]), PROT ? 64'h55 : 64'hAA);

    // Starvation: each round fetch loses to data and then withdraws; the fifth round forces fetch.
    for (int r = 0; r < 6; r++) begin
      tick();
      if_req = 1'b1; if_addr = 8'h01; d_req = 1'b1; d_we = 1'b0; d_addr = 8'hFE; d_wdata = 8'h00;
      #1;
      chk($sformatf("starve%0d.idle", r), 64'(mem_addr), 64'h0);
      tick();
      if_req = 1'b0;
      #1;
      chk($sformatf("starve%0d.grant", r), 64'(mem_addr), (r == 4) ? 64'h01 : 64'hFE);
      tick();
      d_req = 1'b0;
      #1;
      chk($sformatf("starve%0d.if_valid", r), 64'(if_valid), 64'(r == 4));
      chk($sformatf("starve%0d.d_valid", r),  64'(d_valid),  64'(r != 4));
    end
    chk("starve.d_rdata",  64'(d_rdata),  64'(pre(254)));
    chk("starve.if_rdata", 64'(if_rdata), 64'(pre(1)));

    // Random phase against the rule model, starting from reset.
    tick(); rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
    tick();
    m_acc = 0; m_own_d = 0; m_we = 0; m_iv = 0; m_dv = 0; m_flt = 0;
    m_addr = '0; m_wd = '0; m_ird = '0; m_drd = '0; m_starve = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_a[i];

    for (int c = 0; c < 3000; c++) begin
      bit         blocked, e_wen, e_is, e_ds, ie, de, win_i;
      bit         n_iv, n_dv;
      logic [7:0] e_ma, e_mwd;
      logic [63:0] exp_v, act_v;

      tick();
      rst_n = ($urandom_range(0, 149) != 0);
      if (if_req && !m_iv && ($urandom_range(0, 15) != 0)) begin
        if_req = 1'b1;
      end else begin
        if_req  = $urandom_range(0, 1) == 1;
        if_addr = ($urandom_range(0, 7) == 0) ? {8{1'($urandom_range(0, 1))}} : 8'($urandom);
      end
      if (d_req && !m_dv && ($urandom_range(0, 15) != 0)) begin
        d_req = 1'b1;
      end else begin
        d_req   = $urandom_range(0, 1) == 1;
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = ($urandom_range(0, 7) == 0) ? {8{1'($urandom_range(0, 1))}} : 8'($urandom);
        d_wdata = 8'($urandom);
      end
      #1;

      blocked = PROT && m_acc && m_own_d && m_we && (m_addr < 8'd128);
      e_ma    = m_acc ? m_addr : 8'h00;
      e_mwd   = m_acc ? m_wd : 8'h00;
      e_wen   = rst_n && m_acc && m_own_d && m_we && !blocked;
      e_is    = if_req && !m_iv;
      e_ds    = d_req && !m_dv;
      exp_v = 64'({e_ma, e_mwd, e_wen, m_iv, m_ird, e_is, m_dv, m_drd, e_ds, m_flt});
      act_v = 64'({mem_addr, mem_wdata, mem_wen, if_valid, if_rdata, if_stall, d_valid, d_rdata, d_stall, fault});
      chk($sformatf("rand%0d.outputs", c), act_v, exp_v);

      if (!rst_n) begin
        m_acc = 0; m_own_d = 0; m_we = 0; m_iv = 0; m_dv = 0; m_flt = 0;
        m_addr = '0; m_wd = '0; m_ird = '0; m_drd = '0; m_starve = 0;
      end else if (m_acc) begin
        n_iv = !m_own_d;
        n_dv = m_own_d;
        if (!m_own_d) m_ird = ref_mem[m_addr];
        else if (!m_we) m_drd = ref_mem[m_addr];
        else if (!blocked) ref_mem[m_addr] = m_wd;
        m_flt = blocked;
        m_iv = n_iv; m_dv = n_dv; m_acc = 0;
      end else begin
        ie = if_req && !m_iv;
        de = d_req && !m_dv;
        m_iv = 0; m_dv = 0; m_flt = 0;
        if (ie || de) begin
          win_i = ie && (!de || m_starve == LIM);
          if (win_i) begin
            m_starve = 0; m_own_d = 0; m_addr = if_addr; m_wd = 8'h00; m_we = 0;
          end else begin
            if (if_req && m_starve < LIM) m_starve++;
            m_own_d = 1; m_addr = d_addr; m_wd = d_wdata; m_we = d_we;
          end
          m_acc = 1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
